hazard_ctrl: RTL

- Pipeline hazard controller between ID and EX.
- Tracks in-flight destination registers in a scoreboard and drives `data_hazard`/`PC_hazard` into the ID/EX pipeline register.
- Also drives the PC-hold and IF/ID-flush strobes.
- Sequences multi-cycle control-hazard flushes after an EX-stage redirect (taken branch, call, ret).

---
 rtl/cpu_pipe_pkg.sv | 18 +
 rtl/hazard_scoreboard.sv | 40 ++++
 rtl/hazard_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: register width, hazard FSM states, scoreboard entry.
package cpu_pipe_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination shift register (entry 0 = youngest) with RAW comparators.
module hazard_scoreboard
    import cpu_pipe_pkg::*;
#(
    parameter int PIPE_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_v,
    input  logic [REG_W-1:0] push_rd,
    input  logic [REG_W-1:0] rs1,
    input  logic             rs1_used,
    input  logic [REG_W-1:0] rs2,
    input  logic             rs2_used,
    output logic             raw_match
);

    sb_entry_t sb [PIPE_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) sb[k] <= '0;
        end else begin
            sb[0] <= '{v: push_v, rd: push_rd};
            for (int k = 1; k < PIPE_DEPTH; k++) sb[k] <= sb[k-1];
        end
    end

    // r0 is hard-wired, so a read of it can never depend on an older write
    always_comb begin
        raw_match = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (sb[k].v &&
                ((rs1_used && rs1 != ZERO_REG && sb[k].rd == rs1) ||
                 (rs2_used && rs2 != ZERO_REG && sb[k].rd == rs2)))
                raw_match = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: RAW stall via scoreboard, multi-cycle redirect flush FSM.
// Define HAZARD_STATS_EN to add saturating stall_cnt / flush_cnt outputs.
module hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int PIPE_DEPTH   = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic             id_rs1_used,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             ex_redirect,
    output logic             data_hazard,
    output logic             PC_hazard,
    output logic             pc_stall,
    output logic             ifid_flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
`endif
);

    hz_state_t  state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       raw_match;
    logic       issue;
    logic       push_v;

    assign issue  = id_valid & ~data_hazard & ~PC_hazard;
    assign push_v = issue & id_regwrite & (id_rd != ZERO_REG);

    hazard_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .push_v    (push_v),
        .push_rd   (id_rd),
        .rs1       (id_rs1),
        .rs1_used  (id_rs1_used),
        .rs2       (id_rs2),
        .rs2_used  (id_rs2_used),
        .raw_match (raw_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The redirect cycle itself is the first flush cycle, so FLUSH covers the remaining ones
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RUN: begin
                if (ex_redirect && FLUSH_CYCLES > 1) begin
                    state_next = FLUSH;
                    cnt_next   = 3'(FLUSH_CYCLES - 2);
                end
            end
            FLUSH: begin
                if (cnt == '0) state_next = RUN;
                else           cnt_next   = cnt - 3'd1;
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        PC_hazard   = (state == FLUSH) | ex_redirect;
        data_hazard = id_valid & ~PC_hazard & raw_match;
        pc_stall    = data_hazard;
        ifid_flush  = PC_hazard;
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (data_hazard && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (state == RUN && ex_redirect && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule
